// File: rtl/mod_cache_pkg.sv
// Shared definitions for the direct-mapped write-through cache:
// controller state encoding and address-split helpers.
package mod_cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DFILL  = 2'd1,
        IFILL  = 2'd2,
        DWRITE = 2'd3
    } cache_state_t;

    localparam int ADDR_W        = 32;
    localparam int WORD_OFFSET_W = 2;

    // Tag width left over once the word offset and the line index are removed.
    function automatic int tag_width(input int index_width);
        return ADDR_W - index_width - WORD_OFFSET_W;
    endfunction

endpackage

// File: rtl/cache_dp_array.sv
// Storage array with two asynchronous read ports and one synchronous write
// port; used for both the data words and the tags of the cache.
module cache_dp_array #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] rdata_b
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    // Single write port, committed on the rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/mod_cache_dm.sv
// Direct-mapped, unified, write-through cache controller between the CPU
// instruction/data ports and the SRAM backend. Misses and stores are
// serialised through one backend transaction at a time (data before
// instruction), with valid bits, flush and hit/miss counters.
module mod_cache_dm
    import mod_cache_pkg::*;
#(
    parameter int INDEX_WIDTH    = 11,
    parameter bit WRITE_ALLOCATE = 1'b1,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ie,
    input  logic [31:0]          iaddr,
    input  logic                 de,
    input  logic [31:0]          daddr,
    input  logic                 drw,
    input  logic [31:0]          din,
    output logic [31:0]          iout,
    output logic [31:0]          dout,
    output logic                 cpu_stall,
    input  logic                 flush,
    output logic                 mem_ie,
    output logic                 mem_de,
    output logic [31:0]          mem_iaddr,
    output logic [31:0]          mem_daddr,
    output logic                 mem_drw,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_iout,
    input  logic [31:0]          mem_dout,
    input  logic                 mem_rdy,
    output logic [CNT_WIDTH-1:0] cnt_ihit,
    output logic [CNT_WIDTH-1:0] cnt_imiss,
    output logic [CNT_WIDTH-1:0] cnt_dhit,
    output logic [CNT_WIDTH-1:0] cnt_dmiss
);

    localparam int TAG_W = tag_width(INDEX_WIDTH);
    localparam int LINES = 1 << INDEX_WIDTH;

    cache_state_t state, state_nxt;

    logic [LINES-1:0]       valid;
    logic                   flush_pend;
    logic                   wr_done;
    logic [INDEX_WIDTH-1:0] iidx, didx, widx;
    logic [TAG_W-1:0]       itag, dtag, itag_rd, dtag_rd, wtag;
    logic [31:0]            wdata;
    logic                   arr_we, set_valid;
    logic                   ihit, dhit;
    logic                   ifill_req, dfill_req, dwrite_req;
    logic                   done, apply_flush;
    logic                   unused_addr_bits;

    // Byte offset bits never take part in the lookup.
    assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

    assign iidx = iaddr[INDEX_WIDTH+1:2];
    assign itag = iaddr[31:INDEX_WIDTH+2];
    assign didx = daddr[INDEX_WIDTH+1:2];
    assign dtag = daddr[31:INDEX_WIDTH+2];

    cache_dp_array #(
        .ADDR_WIDTH (INDEX_WIDTH),
        .DATA_WIDTH (32)
    ) u_data (
        .clk     (clk),
        .we      (arr_we && !rst),
        .waddr   (widx),
        .wdata   (wdata),
        .raddr_a (iidx),
        .rdata_a (iout),
        .raddr_b (didx),
        .rdata_b (dout)
    );

    cache_dp_array #(
        .ADDR_WIDTH (INDEX_WIDTH),
        .DATA_WIDTH (TAG_W)
    ) u_tag (
        .clk     (clk),
        .we      (arr_we && !rst),
        .waddr   (widx),
        .wdata   (wtag),
        .raddr_a (iidx),
        .rdata_a (itag_rd),
        .raddr_b (didx),
        .rdata_b (dtag_rd)
    );

    assign ihit = valid[iidx] && (itag_rd == itag);
    assign dhit = valid[didx] && (dtag_rd == dtag);

    // A store that has already been written through is not re-issued while
    // the CPU still presents it: wr_done lets the stall drop for exactly the
    // cycle in which the CPU retires the store.
    assign ifill_req  = ie && !ihit;
    assign dfill_req  = de && !drw && !dhit;
    assign dwrite_req = de && drw && !wr_done;

    assign cpu_stall = (state != IDLE) || ifill_req || dfill_req || dwrite_req;

    assign done        = mem_rdy && (state != IDLE);
    assign apply_flush = (flush || flush_pend) && ((state == IDLE) || done);

    // Controller state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, backend request and array-update decode.
    always_comb begin
        state_nxt = state;
        mem_ie    = 1'b0;
        mem_de    = 1'b0;
        mem_drw   = 1'b0;
        mem_iaddr = 32'h0;
        mem_daddr = 32'h0;
        mem_din   = 32'h0;
        arr_we    = 1'b0;
        set_valid = 1'b0;
        widx      = didx;
        wtag      = dtag;
        wdata     = mem_dout;
        case (state)
            IDLE: begin
                if (dwrite_req) begin
                    state_nxt = DWRITE;
                end else if (dfill_req) begin
                    state_nxt = DFILL;
                end else if (ifill_req) begin
                    state_nxt = IFILL;
                end
            end
            DFILL: begin
                mem_de    = 1'b1;
                mem_daddr = daddr;
                if (mem_rdy) begin
                    arr_we    = 1'b1;
                    set_valid = 1'b1;
                    state_nxt = IDLE;
                end
            end
            IFILL: begin
                mem_ie    = 1'b1;
                mem_iaddr = iaddr;
                widx      = iidx;
                wtag      = itag;
                wdata     = mem_iout;
                if (mem_rdy) begin
                    arr_we    = 1'b1;
                    set_valid = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DWRITE: begin
                mem_de    = 1'b1;
                mem_drw   = 1'b1;
                mem_daddr = daddr;
                mem_din   = din;
                wdata     = din;
                if (mem_rdy) begin
                    state_nxt = IDLE;
                    if (dhit || WRITE_ALLOCATE) begin
                        arr_we    = 1'b1;
                        set_valid = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Valid bits and deferred flush; a flush beats a completing fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            flush_pend <= 1'b0;
        end else if (apply_flush) begin
            valid      <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (flush) begin
                flush_pend <= 1'b1;
            end
            if (set_valid && !rst) begin
                valid[widx] <= 1'b1;
            end
        end
    end

    // Remembers a completed write-through until the CPU retires the store.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_done <= 1'b0;
        end else if ((state == DWRITE) && mem_rdy) begin
            wr_done <= 1'b1;
        end else if ((state == IDLE) && !cpu_stall) begin
            wr_done <= 1'b0;
        end
    end

    // Wrapping hit/miss counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ihit  <= '0;
            cnt_imiss <= '0;
            cnt_dhit  <= '0;
            cnt_dmiss <= '0;
        end else begin
            if (ie && ihit && !cpu_stall) begin
                cnt_ihit <= cnt_ihit + CNT_WIDTH'(1);
            end
            if (de && !drw && dhit && !cpu_stall) begin
                cnt_dhit <= cnt_dhit + CNT_WIDTH'(1);
            end
            if ((state == IDLE) && (state_nxt == IFILL)) begin
                cnt_imiss <= cnt_imiss + CNT_WIDTH'(1);
            end
            if ((state == IDLE) && (state_nxt == DFILL)) begin
                cnt_dmiss <= cnt_dmiss + CNT_WIDTH'(1);
            end
        end
    end

endmodule
